adc_serial_ctrl: RTL and testbench

//  Sequencer for the 8-bit serial ADC (chip-select, serial clock, MSB-first data out).

---
 rtl/adc_serial_ctrl_pkg.sv | 26 ++
 rtl/adc_serial_ctrl_tick_gen.sv | 35 +++
 rtl/adc_serial_ctrl.sv | 144 ++++++++++++++
 tb/tb_adc_serial_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_serial_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adc_serial_ctrl_pkg : FSM states and default timing for the serial ADC  (rev 1.0)
// ----------------------------------------------------------------------------
package adc_serial_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SHIFT = 2'd2,
      ST_CONV  = 2'd3
   } state_t;

   localparam int DEF_DATA_W       = 8;
   localparam int DEF_CLK_DIV_HALF = 128;
   localparam int DEF_CS_SETUP     = 72;
   localparam int DEF_CONV_CYC     = 1200;
   localparam int DEF_AUTO_PERIOD  = 48000;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/adc_serial_ctrl_tick_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adc_serial_ctrl_tick_gen : terminal-count divider, 1-cycle tick every DIV enabled cycles  (rev 1.0)
// ----------------------------------------------------------------------------
module adc_serial_ctrl_tick_gen
   import adc_serial_ctrl_pkg::*;
#(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int           W  = cnt_w(DIV);
   localparam logic [W-1:0] TC = W'(DIV - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == TC) ? '0 : cnt + W'(1);
      end
   end

   assign tick = en && !clr && (cnt == TC);

endmodule
`default_nettype wire

// File: rtl/adc_serial_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adc_serial_ctrl : serial ADC sequencer (CS setup, MSB-first shift, conversion gap)  (rev 1.0)
// ----------------------------------------------------------------------------
module adc_serial_ctrl
   import adc_serial_ctrl_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int CLK_DIV_HALF = DEF_CLK_DIV_HALF,
   parameter int CS_SETUP     = DEF_CS_SETUP,
   parameter int CONV_CYC     = DEF_CONV_CYC,
   parameter int AUTO_PERIOD  = DEF_AUTO_PERIOD
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              auto_en,
   output logic              busy,
   output logic              ovr,
   output logic              adcsn,
   output logic              adclk,
   input  logic              addat,
   output logic [DATA_W-1:0] dout,
   output logic              dvalid
);

   localparam int CYC_W = cnt_w((CS_SETUP > CONV_CYC) ? CS_SETUP : CONV_CYC);
   localparam int BIT_W = cnt_w(DATA_W);
   localparam logic [CYC_W-1:0] SETUP_TC = CYC_W'(CS_SETUP - 1);
   localparam logic [CYC_W-1:0] CONV_TC  = CYC_W'(CONV_CYC - 1);
   localparam logic [BIT_W-1:0] BIT_TC   = BIT_W'(DATA_W - 1);

   state_t            state;
   logic [CYC_W-1:0]  cyc_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic              pending;
   logic              prime;
   logic              half_tick;
   logic              auto_tick;
   logic              req;

   assign req = start | auto_tick;

   adc_serial_ctrl_tick_gen #(.DIV(CLK_DIV_HALF)) u_half_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (state == ST_SHIFT),
      .clr   (state != ST_SHIFT),
      .tick  (half_tick)
   );

   adc_serial_ctrl_tick_gen #(.DIV(AUTO_PERIOD)) u_auto_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (auto_en),
      .clr   (!auto_en),
      .tick  (auto_tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         cyc_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         pending <= 1'b0;
         prime   <= 1'b1;
         busy    <= 1'b0;
         ovr     <= 1'b0;
         adcsn   <= 1'b1;
         adclk   <= 1'b0;
         dout    <= '0;
         dvalid  <= 1'b0;
      end else begin
         ovr    <= 1'b0;
         dvalid <= 1'b0;

         // One-deep request slot while a transaction is in flight.
         if (state != ST_IDLE && req) begin
            if (pending) begin
               ovr <= 1'b1;
            end else begin
               pending <= 1'b1;
            end
         end

         case (state)
            ST_IDLE: begin
               if (req || pending) begin
                  state   <= ST_SETUP;
                  busy    <= 1'b1;
                  adcsn   <= 1'b0;
                  cyc_cnt <= '0;
                  pending <= 1'b0;
               end
            end
            ST_SETUP: begin
               if (cyc_cnt == SETUP_TC) begin
                  state   <= ST_SHIFT;
                  adclk   <= 1'b1;
                  bit_cnt <= '0;
                  shreg   <= {shreg[DATA_W-2:0], addat};
               end else begin
                  cyc_cnt <= cyc_cnt + CYC_W'(1);
               end
            end
            ST_SHIFT: begin
               if (half_tick) begin
                  if (adclk) begin
                     adclk <= 1'b0;
                  end else if (bit_cnt == BIT_TC) begin
                     // First read after reset carries the stale power-on conversion.
                     state   <= ST_CONV;
                     adcsn   <= 1'b1;
                     cyc_cnt <= '0;
                     if (prime) begin
                        prime <= 1'b0;
                     end else begin
                        dout   <= shreg;
                        dvalid <= 1'b1;
                     end
                  end else begin
                     adclk   <= 1'b1;
                     bit_cnt <= bit_cnt + BIT_W'(1);
                     shreg   <= {shreg[DATA_W-2:0], addat};
                  end
               end
            end
            ST_CONV: begin
               if (cyc_cnt == CONV_TC) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  cyc_cnt <= cyc_cnt + CYC_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_adc_serial_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_adc_serial_ctrl : self-checking bench with ADC model and transaction scoreboard  (rev 1.0)
// ----------------------------------------------------------------------------
module tb_adc_serial_ctrl;

   localparam int DW        = 8;
   localparam int HALF      = 2;
   localparam int CSS       = 3;
   localparam int CONV      = 10;
   localparam int AUTO      = 100;
   localparam int SHIFT_CYC = 2 * DW * HALF;

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b1;
   logic          start   = 1'b0;
   logic          auto_en = 1'b0;
   logic          addat   = 1'b0;
   logic          busy, ovr, adcsn, adclk, dvalid;
   logic [DW-1:0] dout;

   always #5 clk = ~clk;

   adc_serial_ctrl #(
      .DATA_W       (DW),
      .CLK_DIV_HALF (HALF),
      .CS_SETUP     (CSS),
      .CONV_CYC     (CONV),
      .AUTO_PERIOD  (AUTO)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .auto_en (auto_en),
      .busy    (busy),
      .ovr     (ovr),
      .adcsn   (adcsn),
      .adclk   (adclk),
      .addat   (addat),
      .dout    (dout),
      .dvalid  (dvalid)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ADC model: MSB presented at CS fall, next bit after each ADCLK fall.
   logic [DW-1:0] adc_val   = 8'hA5;
   logic [DW-1:0] m_sh;
   bit            glitch_en = 1'b0;

   initial begin
      forever begin
         @(negedge adcsn);
         m_sh  = adc_val;
         addat = m_sh[DW-1];
         for (int b = 0; b < DW; b++) begin
            @(posedge adclk or posedge adcsn);
            if (adcsn) break;
            if (glitch_en) begin
               #3 addat = ~addat;
            end
            @(negedge adclk or posedge adcsn);
            if (adcsn) break;
            m_sh  = m_sh << 1;
            addat = m_sh[DW-1];
         end
      end
   end

   typedef struct {
      logic          dv;
      logic [DW-1:0] d;
   } exp_t;

   exp_t sb[$];
   exp_t e_push, e_pop;
   int   cyc = 0, t_fall = 0, rises = 0, last_rise = -1, prev_fall = -1;
   int   n_done = 0, n_dvalid = 0, n_ovr = 0, n_falls = 0;
   bit   auto_mode = 1'b0, tb_prime = 1'b1, in_txn = 1'b0;
   logic dv_seen = 1'b0;
   logic p_cs = 1'b1, p_ck = 1'b0;

   // Monitor: timing checks per transaction, scoreboard pop at each CS rise.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            sb.delete();
            tb_prime  = 1'b1;
            in_txn    = 1'b0;
            last_rise = -1;
         end else begin
            if (ovr) n_ovr++;
            if (p_cs && !adcsn) begin
               if (last_rise >= 0) check("conv_gap_min", 32'(cyc - last_rise >= CONV), 1);
               if (auto_mode && prev_fall >= 0) check("auto_period", cyc - prev_fall, AUTO);
               prev_fall = cyc;
               n_falls++;
               t_fall    = cyc;
               rises     = 0;
               in_txn    = 1'b1;
               e_push.dv = !tb_prime;
               e_push.d  = adc_val;
               sb.push_back(e_push);
               tb_prime  = 1'b0;
            end
            if (!p_ck && adclk) begin
               rises++;
               if (rises == 1) check("cs_setup", cyc - t_fall, CSS);
            end
            if (!p_cs && adcsn && in_txn) begin
               in_txn    = 1'b0;
               n_done++;
               last_rise = cyc;
               check("txn_len", cyc - t_fall, CSS + SHIFT_CYC);
               check("adclk_pulses", rises, DW);
               if (sb.size() == 0) begin
                  check("sb_underflow", 0, 1);
               end else begin
                  e_pop = sb.pop_front();
                  check("dvalid_at_cs_rise", dvalid, e_pop.dv);
                  if (e_pop.dv) check("dout_sb", dout, e_pop.d);
               end
            end else if (dvalid) begin
               check("stray_dvalid", 0, 1);
            end
            if (dvalid) begin
               n_dvalid++;
               dv_seen = 1'b1;
            end
         end
         p_cs = adcsn;
         p_ck = adclk;
      end
   end

   task automatic wait_for(input int sel, input logic val, input int max, input string name);
      int   n = 0;
      logic s;
      do begin
         @(negedge clk);
         #1;
         n++;
         s = (sel == 0) ? busy : (sel == 1) ? adclk : adcsn;
      end while (s !== val && n < max);
      if (s !== val) check(name, s, val);
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_adcsn", adcsn, 1);
      check("rst_adclk", adclk, 0);
      check("rst_busy", busy, 0);
      check("rst_ovr", ovr, 0);
      check("rst_dvalid", dvalid, 0);
      check("rst_dout", dout, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   typedef struct {
      bit            rst;
      logic [DW-1:0] val;
      bit            glitch;
      logic          exp_dv;
      logic [DW-1:0] exp_dout;
   } vec_t;

   vec_t vt[6];
   int   n0, f0, d0, e_rise;

   initial begin
      vt[0] = '{rst: 1'b1, val: 8'hA5, glitch: 1'b0, exp_dv: 1'b0, exp_dout: 8'h00};
      vt[1] = '{rst: 1'b0, val: 8'h3C, glitch: 1'b0, exp_dv: 1'b1, exp_dout: 8'h3C};
      vt[2] = '{rst: 1'b0, val: 8'h5A, glitch: 1'b1, exp_dv: 1'b1, exp_dout: 8'h5A};
      vt[3] = '{rst: 1'b0, val: 8'hFF, glitch: 1'b0, exp_dv: 1'b1, exp_dout: 8'hFF};
      vt[4] = '{rst: 1'b0, val: 8'h00, glitch: 1'b1, exp_dv: 1'b1, exp_dout: 8'h00};
      vt[5] = '{rst: 1'b0, val: 8'h81, glitch: 1'b1, exp_dv: 1'b1, exp_dout: 8'h81};
      #1;

      for (int i = 0; i < 6; i++) begin
         if (vt[i].rst) do_reset();
         adc_val   = vt[i].val;
         glitch_en = vt[i].glitch;
         dv_seen   = 1'b0;
         pulse_start();
         wait_for(0, 1'b0, 200, "idle_timeout");
         check($sformatf("vec%0d_dvalid", i), dv_seen, vt[i].exp_dv);
         check($sformatf("vec%0d_dout", i), dout, vt[i].exp_dout);
      end
      glitch_en = 1'b0;

      // Request during SHIFT is held; a second one while held overflows.
      n0      = n_done;
      n_ovr   = 0;
      adc_val = 8'h96;
      pulse_start();
      wait_for(1, 1'b1, 50, "shift_timeout");
      pulse_start();
      check("no_ovr_first_pending", n_ovr, 0);
      wait_for(2, 1'b1, 100, "cs_rise_timeout");
      e_rise = last_rise;
      pulse_start();
      wait_for(2, 1'b0, 50, "pending_timeout");
      check("pending_start_gap", t_fall - e_rise, CONV + 1);
      check("ovr_pulses", n_ovr, 1);
      wait_for(0, 1'b0, 200, "idle_timeout");
      check("pending_txns", n_done - n0, 2);
      check("pending_dout", dout, 8'h96);

      // Auto trigger for 1000 cycles.
      n0        = n_falls;
      d0        = n_dvalid;
      n_ovr     = 0;
      adc_val   = 8'h4B;
      prev_fall = -1;
      auto_mode = 1'b1;
      @(posedge clk);
      #1 auto_en = 1'b1;
      repeat (10 * AUTO) @(posedge clk);
      #1 auto_en = 1'b0;
      wait_for(0, 1'b0, 200, "idle_timeout");
      auto_mode = 1'b0;
      check("auto_falls", n_falls - n0, 10);
      check("auto_dvalids", n_dvalid - d0, 10);
      check("auto_no_ovr", n_ovr, 0);
      f0 = n_falls;
      repeat (2 * AUTO) @(posedge clk);
      check("auto_off_no_req", n_falls - f0, 0);

      // Reset in the middle of SHIFT while ADCLK is high.
      d0      = n_dvalid;
      adc_val = 8'hC3;
      pulse_start();
      wait_for(1, 1'b1, 50, "shift_timeout");
      repeat (4) @(posedge clk);
      #2;
      check("pre_rst_adclk_high", adclk, 1);
      do_reset();
      check("midrst_no_dvalid", n_dvalid - d0, 0);
      dv_seen = 1'b0;
      adc_val = 8'h3C;
      pulse_start();
      wait_for(0, 1'b0, 200, "idle_timeout");
      check("post_rst_prime_dvalid", dv_seen, 0);
      check("post_rst_prime_dout", dout, 8'h00);
      dv_seen = 1'b0;
      adc_val = 8'h69;
      pulse_start();
      wait_for(0, 1'b0, 200, "idle_timeout");
      check("post_rst_dvalid", dv_seen, 1);
      check("post_rst_dout", dout, 8'h69);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t limit 500000", $time);
      $fatal(1);
   end

endmodule
`default_nettype wire
